// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: word width, default fetch start address,
// instruction buffer depth and the fetch request state encoding.
package cpu_pkg;
    localparam int          WORD_W           = 32;
    localparam logic [31:0] RESET_PC         = 32'h0000_3000;
    localparam int          INSTR_FIFO_DEPTH = 4;

    typedef enum logic {
        IDLE,
        REQ
    } fetch_state_t;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers, same-cycle push/pop at full and
// empty, and a synchronous flush that overrides push and pop.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]                   wr_ptr_reg;
    logic [AW:0]                   rd_ptr_reg;
    logic                          do_push;
    logic                          do_pop;
    logic [DEPTH-1:0][WIDTH-1:0]   entry_data;

    assign count   = wr_ptr_reg - rd_ptr_reg;
    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) &&
                     (wr_ptr_reg[AW] != rd_ptr_reg[AW]);
    assign do_pop  = pop && !empty && !flush;
    // A pop in the same cycle frees the slot the push lands in.
    assign do_push = push && (!full || do_pop) && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic [WIDTH-1:0] data_reg;
        always_ff @(posedge clk) begin
            if (do_push && (wr_ptr_reg[AW-1:0] == AW'(gi))) data_reg <= push_data;
        end
        assign entry_data[gi] = data_reg;
    end

    assign pop_data = empty ? '0 : entry_data[rd_ptr_reg[AW-1:0]];

    a_depth_pow2: assert property (@(posedge clk) (DEPTH >= 2) && ((DEPTH & (DEPTH - 1)) == 0));
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !flush && full && !(pop && !empty)));
endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch unit: turns accepted PCs into word reads, tracks in-flight reads,
// buffers returned words with their addresses, and drops stale data on flush.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int          DEPTH    = INSTR_FIFO_DEPTH,
    parameter int          MAX_OUT  = 2,
    parameter logic [31:0] RESET_PC = cpu_pkg::RESET_PC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] pc,
    input  logic              pc_valid,
    output logic              pc_ready,
    input  logic              flush,
    output logic              mem_req,
    output logic [WORD_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic              instr_valid,
    output logic [WORD_W-1:0] instr,
    output logic [WORD_W-1:0] instr_pc,
    input  logic              instr_ready,
    output logic              misalign_err
);
    localparam int OW = $clog2(MAX_OUT + 1);
    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t       state_reg, state_next;
    logic [WORD_W-1:0]  mem_addr_reg, mem_addr_next;
    logic [OW-1:0]      outstanding_reg, outstanding_next;
    logic [OW-1:0]      drop_reg, drop_next;
    logic               misalign_reg, misalign_next;

    logic               held, gnt, resp, keep, accept;
    logic [31:0]        out_after, in_use;
    logic [CW-1:0]      fifo_count, addr_count;
    logic               instr_empty, instr_full, addr_empty, addr_full;
    logic [WORD_W-1:0]  head_addr;

    assign held = (state_reg == REQ);
    assign gnt  = held && mem_gnt;
    assign resp = mem_rvalid && (outstanding_reg != '0);
    assign keep = resp && (drop_reg == '0) && !flush;

    // A request granted this cycle still owes a FIFO slot, so it is counted
    // through out_after; a held ungranted one is counted separately.
    assign out_after = 32'(outstanding_reg) + 32'(gnt);
    assign in_use    = out_after + 32'(fifo_count) + 32'(held && !gnt);
    assign pc_ready  = !flush && (!held || gnt) &&
                       (in_use < 32'(DEPTH)) && (out_after < 32'(MAX_OUT));
    assign accept    = pc_valid && pc_ready;

    always_comb begin
        state_next       = state_reg;
        mem_addr_next    = mem_addr_reg;
        misalign_next    = misalign_reg || (accept && (pc[1:0] != 2'b00));
        outstanding_next = outstanding_reg + OW'(gnt) - OW'(resp);
        drop_next        = drop_reg;

        if (flush) begin
            drop_next = outstanding_next;
        end else if (resp && (drop_reg != '0)) begin
            drop_next = drop_reg - OW'(1);
        end

        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next    = REQ;
                    mem_addr_next = {pc[WORD_W-1:2], 2'b00};
                end
            end
            REQ: begin
                if (flush) begin
                    state_next = IDLE;
                end else if (gnt) begin
                    if (accept) mem_addr_next = {pc[WORD_W-1:2], 2'b00};
                    else        state_next    = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            mem_addr_reg    <= '0;
            outstanding_reg <= '0;
            drop_reg        <= '0;
            misalign_reg    <= 1'b0;
        end else begin
            state_reg       <= state_next;
            mem_addr_reg    <= mem_addr_next;
            outstanding_reg <= outstanding_next;
            drop_reg        <= drop_next;
            misalign_reg    <= misalign_next;
        end
    end

    assign mem_req      = held;
    assign mem_addr     = mem_addr_reg;
    assign misalign_err = misalign_reg;
    assign instr_valid  = !instr_empty;

    // Holds only the addresses of live reads; reads granted during a flush or
    // still in flight across one are never recorded here.
    sync_fifo #(.WIDTH(WORD_W), .DEPTH(DEPTH)) u_addr_q (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (gnt && !flush),
        .push_data (mem_addr_reg),
        .pop       (keep),
        .pop_data  (head_addr),
        .full      (addr_full),
        .empty     (addr_empty),
        .count     (addr_count)
    );

    sync_fifo #(.WIDTH(2 * WORD_W), .DEPTH(DEPTH)) u_instr_q (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (keep),
        .push_data ({head_addr, mem_rdata}),
        .pop       (instr_ready),
        .pop_data  ({instr_pc, instr}),
        .full      (instr_full),
        .empty     (instr_empty),
        .count     (fifo_count)
    );

    a_reset_pc_aligned: assert property (@(posedge clk) RESET_PC[1:0] == 2'b00);
    a_rvalid_protocol: assert property (@(posedge clk) disable iff (rst)
        mem_rvalid |-> (outstanding_reg != '0));
    a_addr_tracking: assert property (@(posedge clk) disable iff (rst)
        32'(addr_count) == 32'(outstanding_reg - drop_reg));
    a_addr_available: assert property (@(posedge clk) disable iff (rst)
        !(keep && addr_empty) && !(gnt && !flush && addr_full));
    a_instr_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(keep && instr_full && !instr_ready));
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed vector table, queue-based reference
// model under random traffic, and hand sequences for flush and reset.
module tb_instr_fetch_unit;
    localparam int DEPTH   = 4;
    localparam int MAX_OUT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc = '0;
    logic        pc_valid = 1'b0;
    logic        pc_ready;
    logic        flush = 1'b0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b0;
    logic        misalign_err;

    instr_fetch_unit #(.DEPTH(DEPTH), .MAX_OUT(MAX_OUT)) dut (
        .clk          (clk),
        .rst          (rst),
        .pc           (pc),
        .pc_valid     (pc_valid),
        .pc_ready     (pc_ready),
        .flush        (flush),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_gnt      (mem_gnt),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata),
        .instr_valid  (instr_valid),
        .instr        (instr),
        .instr_pc     (instr_pc),
        .instr_ready  (instr_ready),
        .misalign_err (misalign_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          epoch;
    } req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        int          gnt_wait;
        int          rsp_wait;
        logic [31:0] exp_addr;
        logic [31:0] exp_instr;
        logic        exp_mis;
    } vec_t;

    // Reference state: accepted-but-ungranted addresses, granted reads awaiting
    // data (memory side), and the instructions decode should see, in order.
    logic [31:0] pend_q[$];
    req_t        mem_q[$];
    req_t        exp_q[$];
    logic [31:0] popped_q[$];
    int          epoch = 0;
    logic        mis_model = 1'b0;
    logic [31:0] next_pc = '0;
    int          accepted = 0;
    vec_t        vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        pc_valid    = 1'b0;
        flush       = 1'b0;
        mem_gnt     = 1'b0;
        mem_rvalid  = 1'b0;
        mem_rdata   = '0;
        instr_ready = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_req"},      32'(mem_req),      32'd0);
        check({tag, "_mem_addr"},     mem_addr,          32'd0);
        check({tag, "_instr_valid"},  32'(instr_valid),  32'd0);
        check({tag, "_instr"},        instr,             32'd0);
        check({tag, "_instr_pc"},     instr_pc,          32'd0);
        check({tag, "_misalign_err"}, 32'(misalign_err), 32'd0);
    endtask

    // One isolated fetch: present pc, grant after gnt_wait, respond after rsp_wait.
    task automatic run_vec(input vec_t v);
        pc = v.pc;
        pc_valid = 1'b1;
        @(negedge clk);
        check("vec_pc_ready_idle", 32'(pc_ready), 32'd1);
        step();
        pc_valid = 1'b0;
        for (int i = 0; i < v.gnt_wait; i++) begin
            @(negedge clk);
            check("vec_req_held", 32'(mem_req), 32'd1);
            check("vec_addr_held", mem_addr, v.exp_addr);
            check("vec_pc_ready_stall", 32'(pc_ready), 32'd0);
            step();
        end
        mem_gnt = 1'b1;
        @(negedge clk);
        check("vec_mem_addr", mem_addr, v.exp_addr);
        check("vec_pc_ready_gnt", 32'(pc_ready), 32'd1);
        step();
        mem_gnt = 1'b0;
        for (int i = 0; i < v.rsp_wait; i++) step();
        mem_rvalid = 1'b1;
        mem_rdata  = v.data;
        @(negedge clk);
        check("vec_no_early_valid", 32'(instr_valid), 32'd0);
        step();
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        @(negedge clk);
        check("vec_instr_valid", 32'(instr_valid), 32'd1);
        check("vec_instr", instr, v.exp_instr);
        check("vec_instr_pc", instr_pc, v.exp_addr);
        check("vec_misalign", 32'(misalign_err), 32'(v.exp_mis));
        check("vec_req_done", 32'(mem_req), 32'd0);
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        @(negedge clk);
        check("vec_popped", 32'(instr_valid), 32'd0);
        step();
    endtask

    // One clock of model-driven traffic; the percentages steer each input.
    task automatic model_cycle(input int pv_pct, input int gnt_pct, input int rsp_pct,
                               input int rdy_pct, input int fl_pct, input int mis_pct);
        bit   held, gnt_b, rsp_b, pop_b, acc_b, pr_exp;
        int   out_after, in_use;
        req_t r;
        held  = (pend_q.size() != 0);
        pc_valid = ($urandom_range(99) < pv_pct);
        pc    = next_pc | (($urandom_range(99) < mis_pct) ? 32'($urandom_range(3)) : 32'd0);
        gnt_b = held && ($urandom_range(99) < gnt_pct);
        mem_gnt = gnt_b;
        rsp_b = (mem_q.size() != 0) && ($urandom_range(99) < rsp_pct);
        mem_rvalid = rsp_b;
        mem_rdata  = rsp_b ? mem_q[0].data : $urandom;
        instr_ready = ($urandom_range(99) < rdy_pct);
        flush = ($urandom_range(99) < fl_pct);
        out_after = mem_q.size() + int'(gnt_b);
        in_use    = out_after + exp_q.size() + int'(held && !gnt_b);
        pr_exp    = !flush && (!held || gnt_b) && (in_use < DEPTH) && (out_after < MAX_OUT);

        @(negedge clk);
        check("mem_req", 32'(mem_req), 32'(held));
        if (held) check("mem_addr", mem_addr, pend_q[0]);
        check("pc_ready", 32'(pc_ready), 32'(pr_exp));
        check("instr_valid", 32'(instr_valid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            check("instr", instr, exp_q[0].data);
            check("instr_pc", instr_pc, exp_q[0].addr);
        end
        check("misalign_err", 32'(misalign_err), 32'(mis_model));

        acc_b = pc_valid && pc_ready;
        pop_b = instr_ready && (exp_q.size() != 0);
        if (pop_b && !flush) begin
            popped_q.push_back(instr_pc);
            void'(exp_q.pop_front());
        end
        if (rsp_b) begin
            r = mem_q.pop_front();
            if (!flush && r.epoch == epoch) exp_q.push_back(r);
        end
        if (gnt_b) begin
            r.addr  = pend_q.pop_front();
            r.data  = $urandom;
            r.epoch = epoch;
            mem_q.push_back(r);
        end
        if (acc_b) begin
            pend_q.push_back({pc[31:2], 2'b00});
            if (pc[1:0] != 2'b00) mis_model = 1'b1;
            next_pc += 32'd4;
            accepted++;
        end
        if (flush) begin
            exp_q.delete();
            pend_q.delete();
            epoch++;
        end
        step();
    endtask

    initial begin
        int acc0;
        vecs[0] = '{32'h0000_3000, 32'h2008_0005, 0, 1, 32'h0000_3000, 32'h2008_0005, 1'b0};
        vecs[1] = '{32'h0000_3004, 32'h8C22_0004, 3, 0, 32'h0000_3004, 32'h8C22_0004, 1'b0};
        vecs[2] = '{32'h0001_2340, 32'hDEAD_0001, 1, 2, 32'h0001_2340, 32'hDEAD_0001, 1'b0};
        vecs[3] = '{32'h0000_3002, 32'h1234_5678, 0, 0, 32'h0000_3000, 32'h1234_5678, 1'b1};
        vecs[4] = '{32'h7FFF_FFFC, 32'hA5A5_5A5A, 2, 3, 32'h7FFF_FFFC, 32'hA5A5_5A5A, 1'b1};
        vecs[5] = '{32'hFFFF_FFFF, 32'h0F0F_0F0F, 0, 1, 32'hFFFF_FFFC, 32'h0F0F_0F0F, 1'b1};

        idle_inputs();
        #12;
        check_reset_outputs("reset");
        #11;
        rst = 1'b0;
        step();

        foreach (vecs[i]) run_vec(vecs[i]);
        mis_model = 1'b1;

        // Stream with decode stalled: MAX_OUT caps in-flight reads, then DEPTH caps the total.
        next_pc = 32'h0000_3000;
        accepted = 0;
        popped_q.delete();
        repeat (6) model_cycle(100, 100, 0, 0, 0, 0);
        check("stream_accepted_max_out", 32'(accepted), 32'd2);
        repeat (8) model_cycle(100, 100, 100, 0, 0, 0);
        check("stream_accepted_depth", 32'(accepted), 32'd4);
        repeat (8) model_cycle(0, 100, 100, 100, 0, 0);
        check("stream_drained", 32'(popped_q.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < popped_q.size()) check("stream_order", popped_q[i], 32'h3000 + 32'(4 * i));
        end

        // Flush with two reads in flight, then a redirect to 0x4000.
        next_pc = 32'h0000_3100;
        repeat (3) model_cycle(100, 100, 0, 0, 0, 0);
        model_cycle(0, 0, 0, 0, 100, 0);
        idle_inputs();
        @(negedge clk);
        check("flush_fifo_empty", 32'(instr_valid), 32'd0);
        check("flush_req_dropped", 32'(mem_req), 32'd0);
        step();
        next_pc = 32'h0000_4000;
        popped_q.delete();
        acc0 = accepted;
        for (int i = 0; i < 10 && accepted == acc0; i++) model_cycle(100, 100, 100, 0, 0, 0);
        check("flush_new_pc_accepted", 32'(accepted - acc0), 32'd1);
        repeat (10) model_cycle(0, 100, 100, 100, 0, 0);
        check("flush_first_pc", (popped_q.size() > 0) ? popped_q[0] : 32'hDEAD_BEEF, 32'h0000_4000);

        // Flush coinciding with a grant and a response.
        next_pc = 32'h0000_4800;
        model_cycle(100, 100, 0, 0, 0, 0);
        model_cycle(100, 100, 0, 0, 0, 0);
        model_cycle(0, 100, 100, 0, 100, 0);
        next_pc = 32'h0000_5000;
        popped_q.delete();
        acc0 = accepted;
        model_cycle(100, 100, 100, 0, 0, 0);
        check("flush_gnt_rsp_accept_next", 32'(accepted - acc0), 32'd1);
        repeat (10) model_cycle(0, 100, 100, 100, 0, 0);
        check("flush_gnt_rsp_count", 32'(popped_q.size()), 32'd1);
        check("flush_gnt_rsp_first_pc", (popped_q.size() > 0) ? popped_q[0] : 32'hDEAD_BEEF,
              32'h0000_5000);

        // Random traffic against the reference model.
        next_pc = 32'h0000_6000;
        repeat (1500) model_cycle(70, 60, 55, 60, 3, 8);

        // Asynchronous reset in the middle of a stream.
        repeat (4) model_cycle(100, 50, 0, 0, 0, 100);
        idle_inputs();
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        pend_q.delete();
        mem_q.delete();
        exp_q.delete();
        mis_model = 1'b0;
        epoch++;
        @(negedge clk);
        rst = 1'b0;
        step();

        next_pc = 32'h0000_3000;
        repeat (300) model_cycle(70, 60, 55, 60, 3, 0);
        repeat (20) model_cycle(0, 100, 100, 100, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
